// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, widths and colour values.
// Imported by the raster counter and the timing driver.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    localparam coord_t H_SYNC  = 10'd96;
    localparam coord_t H_BACK  = 10'd48;
    localparam coord_t H_DISP  = 10'd640;
    localparam coord_t H_FRONT = 10'd16;
    localparam coord_t H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;

    localparam coord_t V_SYNC  = 10'd2;
    localparam coord_t V_BACK  = 10'd33;
    localparam coord_t V_DISP  = 10'd480;
    localparam coord_t V_FRONT = 10'd10;
    localparam coord_t V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam rgb_t WHITE = 12'hFFF;
    localparam rgb_t BLACK = 12'h000;
    localparam rgb_t RED   = 12'hF00;
    localparam rgb_t GREEN = 12'h0F0;
    localparam rgb_t BLUE  = 12'h00F;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter, registered active-low sync and
// active-window decode. Sync is loaded from the next count so it never skews.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter coord_t TOTAL   = H_TOTAL,
    parameter coord_t SYNC    = H_SYNC,
    parameter coord_t WIN_LO  = H_SYNC + H_BACK,
    parameter coord_t WIN_LEN = H_DISP
) (
    input  logic   clk_25,
    input  logic   rst,
    input  logic   en_i,
    output coord_t cnt_o,
    output logic   wrap_o,
    output logic   sync_n_o,
    output logic   win_o
);

    coord_t cnt_q, cnt_d;
    logic   sync_n_q, sync_n_d;

    assign wrap_o = en_i && (cnt_q == TOTAL - coord_t'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + coord_t'(1);
        end
        sync_n_d = !(cnt_d < SYNC);
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sync_n_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign sync_n_o = sync_n_q;
    assign win_o    = (cnt_q >= WIN_LO) && (cnt_q < WIN_LO + WIN_LEN);

endmodule

// File: rtl/vga_timing_driver.sv
// VGA raster timing: requests pixels one cycle ahead of display and
// drives blanked RGB plus HSYNC/VSYNC to the connector.
module vga_timing_driver
    import vga_pkg::*;
#(
    parameter coord_t H_SYNC  = vga_pkg::H_SYNC,
    parameter coord_t H_BACK  = vga_pkg::H_BACK,
    parameter coord_t H_DISP  = vga_pkg::H_DISP,
    parameter coord_t H_FRONT = vga_pkg::H_FRONT,
    parameter coord_t V_SYNC  = vga_pkg::V_SYNC,
    parameter coord_t V_BACK  = vga_pkg::V_BACK,
    parameter coord_t V_DISP  = vga_pkg::V_DISP,
    parameter coord_t V_FRONT = vga_pkg::V_FRONT
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic [RGB_W-1:0]   pixel_data,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic               data_req,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [RGB_W-1:0]   vga_rgb,
    output logic               frame_start
);

    localparam coord_t HA    = H_SYNC + H_BACK;
    localparam coord_t VA    = V_SYNC + V_BACK;
    localparam coord_t H_TOT = HA + H_DISP + H_FRONT;
    localparam coord_t V_TOT = VA + V_DISP + V_FRONT;

    coord_t h_cnt, v_cnt;
    logic   h_wrap, v_wrap;
    logic   h_win, v_win;
    logic   h_req;
    logic   frame_start_q, frame_start_d;

    vga_axis_counter #(
        .TOTAL  (H_TOT),
        .SYNC   (H_SYNC),
        .WIN_LO (HA),
        .WIN_LEN(H_DISP)
    ) u_h_axis (
        .clk_25  (clk_25),
        .rst     (rst),
        .en_i    (1'b1),
        .cnt_o   (h_cnt),
        .wrap_o  (h_wrap),
        .sync_n_o(vga_hs),
        .win_o   (h_win)
    );

    vga_axis_counter #(
        .TOTAL  (V_TOT),
        .SYNC   (V_SYNC),
        .WIN_LO (VA),
        .WIN_LEN(V_DISP)
    ) u_v_axis (
        .clk_25  (clk_25),
        .rst     (rst),
        .en_i    (h_wrap),
        .cnt_o   (v_cnt),
        .wrap_o  (v_wrap),
        .sync_n_o(vga_vs),
        .win_o   (v_win)
    );

    // Request window leads the display window by one pixel (generator latency)
    assign h_req = (h_cnt >= HA - coord_t'(1))
                && (h_cnt < HA + H_DISP - coord_t'(1));

    assign data_req   = h_req && v_win;
    assign pixel_xpos = data_req ? h_cnt - (HA - coord_t'(1)) : '0;
    assign pixel_ypos = data_req ? v_cnt - VA : '0;
    assign vga_rgb    = (h_win && v_win) ? pixel_data : BLACK;

    assign frame_start_d = h_wrap && v_wrap;

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench: full-size instance with a colour generator model and a
// short-frame instance fed constant white for whole-frame checks.
module tb_vga_timing_driver;

    typedef struct {
        int          cyc;
        logic        req;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    logic clk_25 = 1'b0;
    logic rst    = 1'b1;

    always #20 clk_25 = ~clk_25;

    logic [11:0] pd_a, rgb_a, rgb_b;
    logic [9:0]  xa, ya, xb, yb;
    logic        req_a, hs_a, vs_a, fs_a;
    logic        req_b, hs_b, vs_b, fs_b;
    logic [11:0] pd_b = 12'hFFF;

    int checks   = 0;
    int failures = 0;
    int cyc;
    logic chk_en = 1'b0;

    vga_timing_driver u_dut (
        .clk_25     (clk_25),
        .rst        (rst),
        .pixel_data (pd_a),
        .pixel_xpos (xa),
        .pixel_ypos (ya),
        .data_req   (req_a),
        .vga_hs     (hs_a),
        .vga_vs     (vs_a),
        .vga_rgb    (rgb_a),
        .frame_start(fs_a)
    );

    // Same horizontal timing, 12-line frame (VA=5, 4 active lines)
    vga_timing_driver #(
        .V_SYNC (10'd2),
        .V_BACK (10'd3),
        .V_DISP (10'd4),
        .V_FRONT(10'd3)
    ) u_small (
        .clk_25     (clk_25),
        .rst        (rst),
        .pixel_data (pd_b),
        .pixel_xpos (xb),
        .pixel_ypos (yb),
        .data_req   (req_b),
        .vga_hs     (hs_b),
        .vga_vs     (vs_b),
        .vga_rgb    (rgb_b),
        .frame_start(fs_b)
    );

    always @(posedge clk_25 or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Colour generator model: registered, one cycle of latency
    always @(posedge clk_25) begin
        pd_a <= {xa[3:0], ya[3:0], 4'hA};
    end

    function automatic logic [35:0] pack_a();
        return {req_a, xa, ya, hs_a, vs_a, rgb_a, fs_a};
    endfunction

    function automatic logic [35:0] pack_b();
        return {req_b, xb, yb, hs_b, vs_b, rgb_b, fs_b};
    endfunction

    function automatic vec_t mk(int c, logic r, int x, int y,
                                logic hs, logic vs, logic [11:0] rgb);
        vec_t v;
        v.cyc = c;
        v.req = r;
        v.x   = x[9:0];
        v.y   = y[9:0];
        v.hs  = hs;
        v.vs  = vs;
        v.rgb = rgb;
        return v;
    endfunction

    task automatic check(string name, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(int n);
        int guard = 0;
        while (cyc < n && guard < 60000) begin
            @(negedge clk_25);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: got %0d want %0d", cyc, n);
        end
    endtask

    // Whole-frame checker for the short-frame instance
    initial begin
        int h, v, vs_cnt, req_cnt, fs_cnt, last_fs;
        logic ven, rq, ehs, evs, efs;
        logic [9:0] ex, ey;
        logic [11:0] ergb;
        vs_cnt = 0; req_cnt = 0; fs_cnt = 0; last_fs = -1;
        forever begin
            @(negedge clk_25);
            if (rst) begin
                vs_cnt = 0; req_cnt = 0; fs_cnt = 0; last_fs = -1;
            end else if (chk_en) begin
                h    = cyc % 800;
                v    = (cyc / 800) % 12;
                ven  = h >= 144 && h < 784 && v >= 5 && v < 9;
                rq   = h >= 143 && h < 783 && v >= 5 && v < 9;
                ex   = rq ? 10'(h - 143) : 10'd0;
                ey   = rq ? 10'(v - 5) : 10'd0;
                ehs  = h >= 96;
                evs  = v >= 2;
                efs  = cyc != 0 && h == 0 && v == 0;
                ergb = ven ? 12'hFFF : 12'h000;
                check("small_cycle", pack_b(),
                      {rq, ex, ey, ehs, evs, ergb, efs});
                if (!vs_b) vs_cnt++;
                if (req_b) req_cnt++;
                if (fs_b) begin
                    fs_cnt++;
                    if (last_fs < 0) check_int("fs_first", cyc, 9600);
                    else check_int("fs_period", cyc - last_fs, 9600);
                    last_fs = cyc;
                end
                if (cyc % 9600 == 9599) begin
                    check_int("vs_low_cycles", vs_cnt, 1600);
                    check_int("req_per_frame", req_cnt, 2560);
                    check_int("fs_per_frame", fs_cnt, (cyc >= 9600) ? 1 : 0);
                    vs_cnt = 0; req_cnt = 0; fs_cnt = 0;
                end
            end
        end
    end

    initial begin
        vec_t t1[$];
        vec_t t2[$];
        t1.push_back(mk(0,     0, 0,   0,  0, 0, 12'h000));
        t1.push_back(mk(95,    0, 0,   0,  0, 0, 12'h000));
        t1.push_back(mk(96,    0, 0,   0,  1, 0, 12'h000));
        t1.push_back(mk(799,   0, 0,   0,  1, 0, 12'h000));
        t1.push_back(mk(800,   0, 0,   0,  0, 0, 12'h000));
        t1.push_back(mk(1599,  0, 0,   0,  1, 0, 12'h000));
        t1.push_back(mk(1600,  0, 0,   0,  0, 1, 12'h000));
        t1.push_back(mk(1696,  0, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(27343, 0, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(27500, 0, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(28142, 0, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(28143, 1, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(28144, 1, 1,   0,  1, 1, 12'h00A));
        t1.push_back(mk(28150, 1, 7,   0,  1, 1, 12'h60A));
        t1.push_back(mk(28782, 1, 639, 0,  1, 1, 12'hE0A));
        t1.push_back(mk(28783, 0, 0,   0,  1, 1, 12'hF0A));
        t1.push_back(mk(28784, 0, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(28799, 0, 0,   0,  1, 1, 12'h000));
        t1.push_back(mk(28943, 1, 0,   1,  1, 1, 12'h000));
        t1.push_back(mk(29100, 1, 157, 1,  1, 1, 12'hC1A));
        t1.push_back(mk(41800, 1, 57,  17, 1, 1, 12'h81A));
        t1.push_back(mk(42800, 1, 257, 18, 1, 1, 12'h02A));

        t2.push_back(mk(0,    0, 0, 0, 0, 0, 12'h000));
        t2.push_back(mk(1,    0, 0, 0, 0, 0, 12'h000));
        t2.push_back(mk(96,   0, 0, 0, 1, 0, 12'h000));
        t2.push_back(mk(800,  0, 0, 0, 0, 0, 12'h000));
        t2.push_back(mk(1599, 0, 0, 0, 1, 0, 12'h000));
        t2.push_back(mk(1600, 0, 0, 0, 0, 1, 12'h000));

        rst = 1'b1;
        repeat (5) @(posedge clk_25);
        @(negedge clk_25);
        check("reset_a", pack_a(), 36'h0);
        check("reset_b", pack_b(), 36'h0);
        @(posedge clk_25);
        #5 rst = 1'b0;
        chk_en = 1'b1;

        foreach (t1[i]) begin
            wait_cyc(t1[i].cyc);
            check($sformatf("vec1_%0d", i), pack_a(),
                  {t1[i].req, t1[i].x, t1[i].y, t1[i].hs, t1[i].vs,
                   t1[i].rgb, 1'b0});
        end

        // Mid-frame reset lands while both instances are in active video
        rst = 1'b1;
        #1;
        check("midrst_a", pack_a(), 36'h0);
        check("midrst_b", pack_b(), 36'h0);
        repeat (3) @(posedge clk_25);
        #5 rst = 1'b0;

        foreach (t2[i]) begin
            wait_cyc(t2[i].cyc);
            check($sformatf("vec2_%0d", i), pack_a(),
                  {t2[i].req, t2[i].x, t2[i].y, t2[i].hs, t2[i].vs,
                   t2[i].rgb, 1'b0});
        end

        wait_cyc(9650);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
